// File: rtl/fmul_pipe_if.sv
// Handshake and data bundle for the pipelined single-precision multiplier.
// The slave side is the multiplier and the master side is the issue/writeback logic.
interface fmul_pipe_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      x1;
    logic [31:0]      x2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      y;
    logic [TAG_W-1:0] out_tag;
    logic             ovf;
    logic             unf;

    modport master (
        output in_valid, x1, x2, in_tag, out_ready,
        input  in_ready, out_valid, y, out_tag, ovf, unf
    );

    modport slave (
        input  in_valid, x1, x2, in_tag, out_ready,
        output in_ready, out_valid, y, out_tag, ovf, unf
    );
endinterface

// File: rtl/fmul_pipe.sv
// Pipelined IEEE-754 single-precision multiplier with RNE rounding, denormal flush,
// and a valid/ready elastic pipeline of STAGES slots carrying result, flags and tag.
module fmul_pipe #(
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic         clk,
    input  logic         rstn,
    fmul_pipe_if.slave   bus
);

    typedef struct packed {
        logic [31:0]      y;
        logic             ovf;
        logic             unf;
        logic [TAG_W-1:0] tag;
    } slot_t;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] vin;
    logic [STAGES-1:0] rdy;
    slot_t             d   [STAGES];
    slot_t             din [STAGES];
    slot_t             res;
    logic              chain;

    logic              s;
    logic [7:0]        e1;
    logic [7:0]        e2;
    logic              z1;
    logic              z2;
    logic              i1;
    logic              i2;
    logic [47:0]       p;
    logic              sh;
    logic [22:0]       mant;
    logic              g;
    logic              st;
    logic [23:0]       mr;
    logic signed [9:0] ex;

    // The whole product is resolved ahead of slot 0, so every operand class
    // (specials included) sees exactly STAGES register stages.
    always_comb begin
        s    = bus.x1[31] ^ bus.x2[31];
        e1   = bus.x1[30:23];
        e2   = bus.x2[30:23];
        z1   = (e1 == 8'd0);
        z2   = (e2 == 8'd0);
        i1   = (e1 == 8'hFF);
        i2   = (e2 == 8'hFF);
        p    = {1'b1, bus.x1[22:0]} * {1'b1, bus.x2[22:0]};
        sh   = p[47];
        if (sh) begin
            mant = p[46:24];
            g    = p[23];
            st   = |p[22:0];
        end else begin
            mant = p[45:23];
            g    = p[22];
            st   = |p[21:0];
        end
        mr = {1'b0, mant} + {23'd0, g & (st | mant[0])};
        // A rounding carry leaves mr[22:0] all zero, which is already the renormalized fraction.
        ex = $signed({2'b00, e1}) + $signed({2'b00, e2}) - 10'sd127
           + $signed({9'd0, sh}) + $signed({9'd0, mr[23]});

        res     = '0;
        res.tag = bus.in_tag;
        if ((i1 && z2) || (i2 && z1)) begin
            res.y = 32'h7FC00000;
        end else if (i1 || i2) begin
            res.y = {s, 8'hFF, 23'd0};
        end else if (z1 || z2) begin
            res.y = {s, 31'd0};
        end else if (ex >= 10'sd255) begin
            res.y   = {s, 8'hFF, 23'd0};
            res.ovf = 1'b1;
        end else if (ex <= 10'sd0) begin
            res.y   = {s, 31'd0};
            res.unf = 1'b1;
        end else begin
            res.y = {s, ex[7:0], mr[22:0]};
        end
    end

    // A slot may load when empty or when its occupant moves on this cycle.
    always_comb begin
        rdy   = '0;
        chain = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain  = !v[k] || chain;
            rdy[k] = chain;
        end
    end

    always_comb begin
        vin    = '0;
        vin[0] = bus.in_valid;
        for (int k = 0; k < STAGES; k++) begin
            din[k] = '0;
        end
        din[0] = res;
        for (int k = 1; k < STAGES; k++) begin
            vin[k] = v[k-1];
            din[k] = d[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v[k] <= vin[k];
                    if (vin[k]) begin
                        d[k] <= din[k];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = v[STAGES-1];
    assign bus.y         = d[STAGES-1].y;
    assign bus.ovf       = d[STAGES-1].ovf;
    assign bus.unf       = d[STAGES-1].unf;
    assign bus.out_tag   = d[STAGES-1].tag;

endmodule

// File: tb/tb_fmul_pipe.sv
// Self-checking bench for fmul_pipe: directed cases on a 3-stage instance plus a
// randomized regression on STAGES=1..4 against an integer-arithmetic reference model.
module tb_fmul_pipe;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] x1 = '0;
    logic [31:0] x2 = '0;
    logic [4:0]  in_tag = '0;
    logic        out_ready = 1'b0;
    logic        rnd_phase = 1'b0;
    int          cyc = 0;

    logic [3:0]  ov_a;
    logic [3:0]  ir_a;
    logic [3:0]  ovf_a;
    logic [3:0]  unf_a;
    logic [31:0] y_a   [4];
    logic [4:0]  tag_a [4];

    int n_checks = 0;
    int n_fail   = 0;
    int tag_ctr  = 0;

    typedef struct {
        logic [31:0] y;
        logic        ovf;
        logic        unf;
        logic [4:0]  tag;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string nm, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, obs, expv);
        end
    endtask

    // Reference: exact integer product, rounded to 24 significant bits by remainder comparison.
    function automatic logic [33:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e, sh;
        longint unsigned p, q, rem, half;
        logic [31:0] r;
        logic ov, un;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ov = 1'b0;
        un = 1'b0;
        if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) r = 32'h7FC00000;
        else if (ea == 255 || eb == 255) r = {s, 8'hFF, 23'd0};
        else if (ea == 0 || eb == 0) r = {s, 31'd0};
        else begin
            p    = ((64'd1 << 23) | 64'(a[22:0])) * ((64'd1 << 23) | 64'(b[22:0]));
            sh   = (p >= (64'd1 << 47)) ? 24 : 23;
            q    = p >> sh;
            rem  = p - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            e = ea + eb - 127 + sh - 23;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e++;
            end
            if (e >= 255) begin
                r  = {s, 8'hFF, 23'd0};
                ov = 1'b1;
            end else if (e <= 0) begin
                r  = {s, 31'd0};
                un = 1'b1;
            end else begin
                r = {s, e[7:0], q[22:0]};
            end
        end
        return {ov, un, r};
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        fmul_pipe_if #(.TAG_W(5)) bus();
        int   rp = 0;
        exp_t e;

        assign bus.in_valid  = in_valid;
        assign bus.x1        = x1;
        assign bus.x2        = x2;
        assign bus.in_tag    = in_tag;
        assign bus.out_ready = out_ready;

        fmul_pipe #(.STAGES(gi + 1), .TAG_W(5)) u_dut (
            .clk  (clk),
            .rstn (rstn),
            .bus  (bus)
        );

        assign ov_a[gi]  = bus.out_valid;
        assign ir_a[gi]  = bus.in_ready;
        assign ovf_a[gi] = bus.ovf;
        assign unf_a[gi] = bus.unf;
        assign y_a[gi]   = bus.y;
        assign tag_a[gi] = bus.out_tag;

        always @(negedge clk) begin
            if (rnd_phase && bus.out_valid) begin
                if (rp < exp_q.size()) begin
                    e = exp_q[rp];
                    check_eq($sformatf("rnd_y_s%0d", gi + 1), bus.y, e.y);
                    check_eq($sformatf("rnd_ovf_s%0d", gi + 1), bus.ovf, e.ovf);
                    check_eq($sformatf("rnd_unf_s%0d", gi + 1), bus.unf, e.unf);
                    check_eq($sformatf("rnd_tag_s%0d", gi + 1), bus.out_tag, e.tag);
                    check_eq($sformatf("rnd_lat_s%0d", gi + 1), cyc - e.acc, gi);
                end else begin
                    check_eq($sformatf("rnd_extra_s%0d", gi + 1), 1, 0);
                end
                rp++;
            end
        end
    end

    task automatic run_one(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ey, input logic eo, input logic eu);
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        x1        = a;
        x2        = b;
        in_tag    = tag_ctr[4:0];
        out_ready = 1'b1;
        #1;
        check_eq({nm, "_rdy"}, ir_a[2], 1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!ov_a[2] && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq({nm, "_lat"}, n, 3);
        check_eq({nm, "_y"}, y_a[2], ey);
        check_eq({nm, "_ovf"}, ovf_a[2], eo);
        check_eq({nm, "_unf"}, unf_a[2], eu);
        check_eq({nm, "_tag"}, tag_a[2], tag_ctr[4:0]);
        tag_ctr++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted, next_out, seen, idx;
        logic [33:0] r;
        exp_t ent;

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check_eq("rst_valid", ov_a[i], 0);
            check_eq("rst_y", y_a[i], 0);
            check_eq("rst_tag", tag_a[i], 0);
            check_eq("rst_flags", {ovf_a[i], unf_a[i]}, 0);
        end
        rstn = 1'b1;

        run_one("one",    32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 0);
        run_one("onept5", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 0, 0);
        run_one("neg",    32'hBF800000, 32'h3F800000, 32'hBF800000, 0, 0);
        run_one("tie",    32'h3F800800, 32'h3F800800, 32'h3F801000, 0, 0);
        run_one("ulp",    32'h3F800001, 32'h3F800001, 32'h3F800002, 0, 0);
        run_one("ovf",    32'h7F000000, 32'h40000000, 32'h7F800000, 1, 0);
        run_one("unf",    32'h20000000, 32'h1F800000, 32'h00000000, 0, 1);
        run_one("infz",   32'hFF800000, 32'h00000000, 32'h7FC00000, 0, 0);
        run_one("zfin",   32'h80000000, 32'h3F800000, 32'h80000000, 0, 0);
        run_one("infn",   32'h7F800000, 32'hC0000000, 32'hFF800000, 0, 0);

        // Back-pressure: the 3-stage instance must fill and then refuse.
        @(negedge clk);
        out_ready = 1'b0;
        accepted  = 0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            in_valid = 1'b1;
            in_tag   = accepted[4:0];
            x1       = 32'h3F800000 | accepted;
            x2       = 32'h40000000;
            #1;
            check_eq("bp_in_ready", ir_a[2], accepted < 3);
            if (ir_a[2]) accepted++;
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_eq("bp_hold_valid", ov_a[2], 1);
            check_eq("bp_hold_y", y_a[2], 32'h40000000);
            check_eq("bp_hold_tag", tag_a[2], 0);
        end
        out_ready = 1'b1;
        next_out  = 0;
        for (int c = 0; c < 30 && next_out < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (ov_a[2]) begin
                check_eq("bp_order_tag", tag_a[2], next_out);
                check_eq("bp_order_y", y_a[2], 32'h40000000 | next_out);
                next_out++;
            end
            if (accepted < 6) begin
                in_valid = 1'b1;
                in_tag   = accepted[4:0];
                x1       = 32'h3F800000 | accepted;
                #1;
                if (ir_a[2]) accepted++;
            end else begin
                in_valid = 1'b0;
            end
        end
        check_eq("bp_count", next_out, 6);
        in_valid = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (ov_a[2]) seen++;
        end
        check_eq("bp_no_dup", seen, 0);

        // Reset with operations in flight.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x1       = 32'h40400000;
            x2       = 32'h40400000;
            in_tag   = 5'd20 + c[4:0];
        end
        @(negedge clk);
        in_valid = 1'b0;
        rstn     = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check_eq("midrst_valid", ov_a[2], 0);
        check_eq("midrst_y", y_a[2], 0);
        check_eq("midrst_tag", tag_a[2], 0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (ov_a != 4'd0) seen++;
        end
        check_eq("midrst_stale", seen, 0);

        // Randomized regression on all four depths.
        rstn = 1'b0;
        @(negedge clk);
        rstn      = 1'b1;
        out_ready = 1'b1;
        rnd_phase = 1'b1;
        idx = 0;
        for (int c = 0; c < 400; c++) begin
            int e1, e2, mode;
            logic [22:0] f1, f2;
            @(negedge clk);
            check_eq("rnd_in_ready", ir_a, 4'hF);
            if ($urandom % 4 != 0) begin
                mode = int'($urandom % 4);
                e1 = int'($urandom_range(254, 1));
                e2 = int'($urandom_range(254, 1));
                if (mode == 1) e2 = 127 - e1 + int'($urandom_range(2, 0));
                if (mode == 2) e2 = 381 - e1 - int'($urandom_range(2, 0));
                if (e2 < 1 || e2 > 254) e2 = int'($urandom_range(254, 1));
                f1 = (mode == 3 || $urandom % 4 == 0) ? 23'h7FFFFF - 23'($urandom % 8) : 23'($urandom);
                f2 = (mode == 3 || $urandom % 4 == 0) ? 23'h7FFFFF - 23'($urandom % 8) : 23'($urandom);
                in_valid = 1'b1;
                x1       = {1'($urandom), e1[7:0], f1};
                x2       = {1'($urandom), e2[7:0], f2};
                in_tag   = idx[4:0];
                r        = ref_mul(x1, x2);
                ent.y    = r[31:0];
                ent.unf  = r[32];
                ent.ovf  = r[33];
                ent.tag  = idx[4:0];
                ent.acc  = cyc + 1;
                exp_q.push_back(ent);
                idx++;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check_eq("rnd_cnt_s1", g_dut[0].rp, exp_q.size());
        check_eq("rnd_cnt_s2", g_dut[1].rp, exp_q.size());
        check_eq("rnd_cnt_s3", g_dut[2].rp, exp_q.size());
        check_eq("rnd_cnt_s4", g_dut[3].rp, exp_q.size());
        rnd_phase = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
